// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: RAW/load-use stall detection, branch flush priority,
// registered EX-stage bypass selects and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bypass_en,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [AW-1:0]    ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [AW-1:0]    mem_rd,
    input  logic             mem_regwrite,
    input  logic             ex_br_taken,
    output logic             hold_pc,
    output logic             bubble_ex,
    output logic             flush_ifid,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0]       FWD_RF    = 2'b00;
    localparam logic [1:0]       FWD_EXMEM = 2'b01;
    localparam logic [1:0]       FWD_MEMWB = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             rs_ex, rt_ex, rs_mem, rt_mem;
    logic             load_use, stall;
    logic [1:0]       fwd_a_d, fwd_a_q;
    logic [1:0]       fwd_b_d, fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    // Source/producer matches; register 0 never creates a dependency
    always_comb begin
        rs_ex  = id_use_rs && (id_rs != '0) && ex_regwrite  && (id_rs == ex_rd);
        rt_ex  = id_use_rt && (id_rt != '0) && ex_regwrite  && (id_rt == ex_rd);
        rs_mem = id_use_rs && (id_rs != '0) && mem_regwrite && (id_rs == mem_rd);
        rt_mem = id_use_rt && (id_rt != '0) && mem_regwrite && (id_rt == mem_rd);
    end

    // Stall resolution and branch-over-stall priority
    always_comb begin
        load_use   = ex_memread && (rs_ex || rt_ex);
        stall      = bypass_en ? load_use : (rs_ex || rt_ex || rs_mem || rt_mem);
        flush_ifid = ex_br_taken;
        bubble_ex  = ex_br_taken || stall;
        hold_pc    = !ex_br_taken && stall;
    end

    // Next bypass selects: the ID instruction moves to EX, so the EX producer sits in EX/MEM
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (bypass_en && !bubble_ex) begin
            if (rs_ex)       fwd_a_d = FWD_EXMEM;
            else if (rs_mem) fwd_a_d = FWD_MEMWB;
            if (rt_ex)       fwd_b_d = FWD_EXMEM;
            else if (rt_mem) fwd_b_d = FWD_MEMWB;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hold_pc && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (ex_br_taken && (flush_cnt_q != CNT_MAX))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
